riscv_exc_responder: RTL and testbench
======================================

# riscv_exc_responder

Controller-side responder for the exception request/acknowledge handshake. It accepts an exception or interrupt request, halts fetch and decode, and waits for outstanding data-memory transactions to drain. It then acknowledges the request, captures EPC and cause, and redirects the PC to the selected vector. It also performs the return redirect for ERET. It sits in the ID-stage controller, between the exception requester and the IF stage / CSR file.

## Interface
- DRAIN_MAX, default 15: maximum number of DRAIN cycles before a forced acknowledge (1..15).
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- exc_req_i  in  1  exception/interrupt request; level, held until acknowledged
- exc_ack_o  out  1  acknowledge; single-cycle pulse
- exc_pc_mux_i  in  2  vector select from requester; valid while exc_req_i=1
- exc_cause_i  in  6  cause from requester; valid while exc_req_i=1
- eret_insn_i  in  1  ERET decoded in ID
- pc_id_i  in  32  PC of the instruction currently in ID
- data_req_pending_i  in  1  LSU transaction outstanding
- dbg_halt_i  in  1  debug unit holds the core; blocks acknowledge
- halt_if_o  out  1  stall the fetch stage
- halt_id_o  out  1  stall the decode stage
- pc_set_o  out  1  redirect the PC this cycle
- pc_sel_o  out  1  redirect target: 0 = exception vector, 1 = EPC (return)
- exc_pc_mux_o  out  2  latched vector select; valid when pc_set_o=1 and pc_sel_o=0
- epc_o  out  32  latched EPC
- cause_o  out  6  latched cause
- csr_save_o  out  1  pulse: CSR file stores epc_o/cause_o and clears the interrupt enable
- csr_restore_o  out  1  pulse: CSR file restores the interrupt enable
- drain_timeout_o  out  1  pulse: acknowledge was forced by timeout

## Operation
- The state machine has four states: IDLE, DRAIN, JUMP and RET. The drain counter is 4 bits wide.
- **IDLE**
  - Request with no LSU transaction pending and no debug halt:
    - exc_ack_o=1 in the same cycle.
    - Latch exc_cause_i, exc_pc_mux_i and pc_id_i.
    - csr_save_o=1; go to JUMP.
  - Request otherwise:
    - halt_if_o=1 and halt_id_o=1 combinationally.
    - Latch cause, vector select and EPC; counter clears to 0; go to DRAIN.
  - ERET with no request: go to RET.
  - A request takes priority over a simultaneous ERET. The ERET is dropped, because the flush kills it.
- **DRAIN**
  - halt_if_o=halt_id_o=1. The counter increments each cycle and saturates at DRAIN_MAX.
  - When data_req_pending_i=0 and dbg_halt_i=0: exc_ack_o=1, csr_save_o=1, go to JUMP.
  - When the counter has reached DRAIN_MAX and dbg_halt_i=0: the same actions, plus drain_timeout_o=1.
  - dbg_halt_i=1 holds the block in DRAIN regardless of the counter. Neither the timeout nor the acknowledge fires while the halt is asserted.
  - The latched cause, vector select and EPC stay frozen while in DRAIN. A change on exc_cause_i is ignored.
- **JUMP** (one cycle): pc_set_o=1, pc_sel_o=0, halt_if_o=1, halt_id_o=0; go to IDLE.
- **RET** (one cycle): pc_set_o=1, pc_sel_o=1, csr_restore_o=1, halt_if_o=1; go to IDLE.
  - A request arriving while in JUMP or RET is not serviced until the block is back in IDLE.
- epc_o, cause_o and exc_pc_mux_o change only on a latch event. They hold their values otherwise.

## Timing
- Reset value of every output is 0, including epc_o, cause_o and exc_pc_mux_o. After reset the state is IDLE and the counter is 0.
- Reset asserted in any state returns the block to IDLE immediately and drops all pulses. A pending acknowledge is lost, so the requester must re-request.
- Best-case latency: request to acknowledge is 0 cycles. The acknowledge to pc_set_o latency is 1 cycle.
- Drain latency: the acknowledge occurs in the first cycle with data_req_pending_i=0, at the earliest one cycle after the request.
- Timeout: without debug halt, the forced acknowledge fires DRAIN_MAX+1 cycles after the request cycle.
- exc_ack_o, csr_save_o, csr_restore_o, drain_timeout_o and pc_set_o are each asserted for exactly one cycle per event.
- exc_ack_o and csr_save_o are always coincident.
- Back-to-back requests: at least one JUMP cycle separates two acknowledges.

## Test plan
- Request with cause 0x25, pc_id_i=0x80, no pending transaction:
  - exc_ack_o and csr_save_o in the same cycle.
  - Next cycle pc_set_o=1 with pc_sel_o=0.
  - epc_o=0x80 and cause_o=0x25.
- Request with data_req_pending_i=1 for 3 cycles:
  - halt_if_o and halt_id_o high from the request cycle.
  - Acknowledge in the 4th cycle; no drain_timeout_o.
  - epc_o holds the request-cycle PC even though pc_id_i changes.
- Pending transaction stuck at 1 with DRAIN_MAX=15: forced acknowledge 16 cycles after the request, with drain_timeout_o=1.
- dbg_halt_i=1 for 20 cycles during DRAIN:
  - No acknowledge and no timeout while the halt is asserted.
  - Acknowledge in the cycle dbg_halt_i falls.
- ERET alone:
  - RET cycle shows pc_set_o=1, pc_sel_o=1 and csr_restore_o=1.
  - Request and ERET together: only the exception path runs.
- Reset asserted in DRAIN and in JUMP: all outputs are 0 immediately and the state is IDLE. After release, a held request is acknowledged afresh.

Source files
------------

// File: rtl/riscv_exc_responder.sv
// Exception request/acknowledge responder for the ID-stage controller.
// Drains the LSU, acknowledges, saves EPC/cause and redirects the PC.
module riscv_exc_responder #(
    parameter int unsigned DRAIN_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exc_req_i,
    output logic        exc_ack_o,
    input  logic [1:0]  exc_pc_mux_i,
    input  logic [5:0]  exc_cause_i,
    input  logic        eret_insn_i,
    input  logic [31:0] pc_id_i,
    input  logic        data_req_pending_i,
    input  logic        dbg_halt_i,
    output logic        halt_if_o,
    output logic        halt_id_o,
    output logic        pc_set_o,
    output logic        pc_sel_o,
    output logic [1:0]  exc_pc_mux_o,
    output logic [31:0] epc_o,
    output logic [5:0]  cause_o,
    output logic        csr_save_o,
    output logic        csr_restore_o,
    output logic        drain_timeout_o
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        JUMP,
        RET
    } state_e;

    localparam logic [3:0] CNT_MAX = 4'(DRAIN_MAX);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] epc_q, epc_d;
    logic [5:0]  cause_q, cause_d;
    logic [1:0]  mux_q, mux_d;

    logic ack, save, restore, tmo;
    logic pc_set, pc_sel, hif, hid;
    logic cnt_max;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        mux_d   = mux_q;
        ack     = 1'b0;
        save    = 1'b0;
        restore = 1'b0;
        tmo     = 1'b0;
        pc_set  = 1'b0;
        pc_sel  = 1'b0;
        hif     = 1'b0;
        hid     = 1'b0;
        cnt_max = (cnt_q == CNT_MAX);

        unique case (state_q)
            IDLE: begin
                if (exc_req_i) begin
                    epc_d   = pc_id_i;
                    cause_d = exc_cause_i;
                    mux_d   = exc_pc_mux_i;
                    cnt_d   = 4'd0;
                    if (!data_req_pending_i && !dbg_halt_i) begin
                        ack     = 1'b1;
                        save    = 1'b1;
                        state_d = JUMP;
                    end else begin
                        hif     = 1'b1;
                        hid     = 1'b1;
                        state_d = DRAIN;
                    end
                end else if (eret_insn_i) begin
                    state_d = RET;
                end
            end
            DRAIN: begin
                hif = 1'b1;
                hid = 1'b1;
                if (!cnt_max) cnt_d = cnt_q + 4'd1;
                // Debug halt overrides both the normal drain and the timeout
                if (!dbg_halt_i && (!data_req_pending_i || cnt_max)) begin
                    ack     = 1'b1;
                    save    = 1'b1;
                    tmo     = data_req_pending_i;
                    state_d = JUMP;
                end
            end
            JUMP: begin
                pc_set  = 1'b1;
                hif     = 1'b1;
                state_d = IDLE;
            end
            RET: begin
                pc_set  = 1'b1;
                pc_sel  = 1'b1;
                restore = 1'b1;
                hif     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset must silence the combinational IDLE-path pulses too
        if (!rst_n) begin
            ack     = 1'b0;
            save    = 1'b0;
            restore = 1'b0;
            tmo     = 1'b0;
            pc_set  = 1'b0;
            pc_sel  = 1'b0;
            hif     = 1'b0;
            hid     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            epc_q   <= 32'd0;
            cause_q <= 6'd0;
            mux_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            mux_q   <= mux_d;
        end
    end

    assign exc_ack_o       = ack;
    assign csr_save_o      = save;
    assign csr_restore_o   = restore;
    assign drain_timeout_o = tmo;
    assign pc_set_o        = pc_set;
    assign pc_sel_o        = pc_sel;
    assign halt_if_o       = hif;
    assign halt_id_o       = hid;
    assign exc_pc_mux_o    = mux_q;
    assign epc_o           = epc_q;
    assign cause_o         = cause_q;

endmodule

// File: tb/tb_riscv_exc_responder.sv
// Directed bench for riscv_exc_responder with an expectation queue.
// Each step pushes the expected outputs; the negedge sample pops them.
module tb_riscv_exc_responder;

    typedef struct packed {
        logic        ack;
        logic        save;
        logic        restore;
        logic        tmo;
        logic        pcset;
        logic        pcsel;
        logic        hif;
        logic        hid;
        logic [1:0]  mux;
        logic [5:0]  cause;
        logic [31:0] epc;
    } o_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exc_req_i;
    logic        exc_ack_o;
    logic [1:0]  exc_pc_mux_i;
    logic [5:0]  exc_cause_i;
    logic        eret_insn_i;
    logic [31:0] pc_id_i;
    logic        data_req_pending_i;
    logic        dbg_halt_i;
    logic        halt_if_o;
    logic        halt_id_o;
    logic        pc_set_o;
    logic        pc_sel_o;
    logic [1:0]  exc_pc_mux_o;
    logic [31:0] epc_o;
    logic [5:0]  cause_o;
    logic        csr_save_o;
    logic        csr_restore_o;
    logic        drain_timeout_o;

    int errors = 0;
    int checks = 0;

    o_t    exp_q[$];
    string tag_q[$];
    o_t    obs;

    always #5 clk = ~clk;

    riscv_exc_responder #(.DRAIN_MAX(15)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .exc_req_i         (exc_req_i),
        .exc_ack_o         (exc_ack_o),
        .exc_pc_mux_i      (exc_pc_mux_i),
        .exc_cause_i       (exc_cause_i),
        .eret_insn_i       (eret_insn_i),
        .pc_id_i           (pc_id_i),
        .data_req_pending_i(data_req_pending_i),
        .dbg_halt_i        (dbg_halt_i),
        .halt_if_o         (halt_if_o),
        .halt_id_o         (halt_id_o),
        .pc_set_o          (pc_set_o),
        .pc_sel_o          (pc_sel_o),
        .exc_pc_mux_o      (exc_pc_mux_o),
        .epc_o             (epc_o),
        .cause_o           (cause_o),
        .csr_save_o        (csr_save_o),
        .csr_restore_o     (csr_restore_o),
        .drain_timeout_o   (drain_timeout_o)
    );

    assign obs = {exc_ack_o, csr_save_o, csr_restore_o, drain_timeout_o,
                  pc_set_o, pc_sel_o, halt_if_o, halt_id_o,
                  exc_pc_mux_o, cause_o, epc_o};

    function automatic o_t mk(input bit ack, input bit save,
                              input bit rs, input bit tmo,
                              input bit pcs, input bit psel,
                              input bit hif, input bit hid,
                              input logic [1:0] m, input logic [5:0] c,
                              input logic [31:0] e);
        o_t r;
        r = {ack, save, rs, tmo, pcs, psel, hif, hid, m, c, e};
        return r;
    endfunction

    // Push expectation, compare at negedge, return to just after posedge
    task automatic step(input string tag, input o_t e);
        o_t    x;
        string t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        x = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (obs === x) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", t, obs, x);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        exc_req_i = 1'b0;
        exc_pc_mux_i = 2'd0;
        exc_cause_i = 6'd0;
        eret_insn_i = 1'b0;
        pc_id_i = 32'd0;
        data_req_pending_i = 1'b0;
        dbg_halt_i = 1'b0;
        #1;
        step("reset", mk(0,0,0,0,0,0,0,0, 2'd0, 6'h00, 32'h0));
        rst_n = 1'b1;

        // Fast path, request held through JUMP
        exc_req_i = 1'b1; exc_cause_i = 6'h25;
        exc_pc_mux_i = 2'd2; pc_id_i = 32'h80;
        step("t1_ack", mk(1,1,0,0,0,0,0,0, 2'd0, 6'h00, 32'h0));
        step("t1_jump", mk(0,0,0,0,1,0,1,0, 2'd2, 6'h25, 32'h80));
        step("t1_reack", mk(1,1,0,0,0,0,0,0, 2'd2, 6'h25, 32'h80));
        exc_req_i = 1'b0;
        step("t1_jump2", mk(0,0,0,0,1,0,1,0, 2'd2, 6'h25, 32'h80));
        step("t1_idle", mk(0,0,0,0,0,0,0,0, 2'd2, 6'h25, 32'h80));

        // Drain for 3 cycles, PC moving meanwhile
        exc_req_i = 1'b1; data_req_pending_i = 1'b1;
        exc_cause_i = 6'h11; exc_pc_mux_i = 2'd1; pc_id_i = 32'h100;
        step("t2_c0", mk(0,0,0,0,0,0,1,1, 2'd2, 6'h25, 32'h80));
        pc_id_i = 32'h104; exc_cause_i = 6'h1e;
        step("t2_c1", mk(0,0,0,0,0,0,1,1, 2'd1, 6'h11, 32'h100));
        pc_id_i = 32'h108;
        step("t2_c2", mk(0,0,0,0,0,0,1,1, 2'd1, 6'h11, 32'h100));
        data_req_pending_i = 1'b0;
        step("t2_ack", mk(1,1,0,0,0,0,1,1, 2'd1, 6'h11, 32'h100));
        exc_req_i = 1'b0;
        step("t2_jump", mk(0,0,0,0,1,0,1,0, 2'd1, 6'h11, 32'h100));

        // Stuck transaction: forced acknowledge 16 cycles later
        exc_req_i = 1'b1; data_req_pending_i = 1'b1;
        exc_cause_i = 6'h3f; exc_pc_mux_i = 2'd3; pc_id_i = 32'h200;
        step("t3_c0", mk(0,0,0,0,0,0,1,1, 2'd1, 6'h11, 32'h100));
        for (int i = 1; i <= 15; i++)
            step("t3_drain", mk(0,0,0,0,0,0,1,1, 2'd3, 6'h3f, 32'h200));
        step("t3_tmo", mk(1,1,0,1,0,0,1,1, 2'd3, 6'h3f, 32'h200));
        exc_req_i = 1'b0; data_req_pending_i = 1'b0;
        step("t3_jump", mk(0,0,0,0,1,0,1,0, 2'd3, 6'h3f, 32'h200));

        // Debug halt holds DRAIN past the timeout point
        exc_req_i = 1'b1; data_req_pending_i = 1'b1;
        exc_cause_i = 6'h05; exc_pc_mux_i = 2'd0; pc_id_i = 32'h300;
        step("t4_c0", mk(0,0,0,0,0,0,1,1, 2'd3, 6'h3f, 32'h200));
        dbg_halt_i = 1'b1; data_req_pending_i = 1'b0;
        for (int i = 0; i < 20; i++)
            step("t4_dbg", mk(0,0,0,0,0,0,1,1, 2'd0, 6'h05, 32'h300));
        dbg_halt_i = 1'b0;
        step("t4_ack", mk(1,1,0,0,0,0,1,1, 2'd0, 6'h05, 32'h300));
        exc_req_i = 1'b0;
        step("t4_jump", mk(0,0,0,0,1,0,1,0, 2'd0, 6'h05, 32'h300));

        // ERET alone, then ERET colliding with a request
        eret_insn_i = 1'b1;
        step("t5_eret", mk(0,0,0,0,0,0,0,0, 2'd0, 6'h05, 32'h300));
        eret_insn_i = 1'b0;
        step("t5_ret", mk(0,0,1,0,1,1,1,0, 2'd0, 6'h05, 32'h300));
        step("t5_idle", mk(0,0,0,0,0,0,0,0, 2'd0, 6'h05, 32'h300));
        exc_req_i = 1'b1; eret_insn_i = 1'b1;
        exc_cause_i = 6'h2a; exc_pc_mux_i = 2'd1; pc_id_i = 32'h400;
        step("t5_both", mk(1,1,0,0,0,0,0,0, 2'd0, 6'h05, 32'h300));
        exc_req_i = 1'b0; eret_insn_i = 1'b0;
        step("t5_jump", mk(0,0,0,0,1,0,1,0, 2'd1, 6'h2a, 32'h400));
        step("t5_idle2", mk(0,0,0,0,0,0,0,0, 2'd1, 6'h2a, 32'h400));

        // Reset in DRAIN with the request still held
        exc_req_i = 1'b1; data_req_pending_i = 1'b1;
        exc_cause_i = 6'h12; exc_pc_mux_i = 2'd2; pc_id_i = 32'h500;
        step("t6_c0", mk(0,0,0,0,0,0,1,1, 2'd1, 6'h2a, 32'h400));
        step("t6_drain", mk(0,0,0,0,0,0,1,1, 2'd2, 6'h12, 32'h500));
        rst_n = 1'b0;
        step("t6_rst", mk(0,0,0,0,0,0,0,0, 2'd0, 6'h00, 32'h0));
        rst_n = 1'b1; data_req_pending_i = 1'b0;
        step("t6_reack", mk(1,1,0,0,0,0,0,0, 2'd0, 6'h00, 32'h0));
        exc_req_i = 1'b0;
        step("t6_jump", mk(0,0,0,0,1,0,1,0, 2'd2, 6'h12, 32'h500));

        // Reset in JUMP with the request still held
        exc_req_i = 1'b1;
        exc_cause_i = 6'h33; exc_pc_mux_i = 2'd3; pc_id_i = 32'h600;
        step("t7_ack", mk(1,1,0,0,0,0,0,0, 2'd2, 6'h12, 32'h500));
        rst_n = 1'b0;
        step("t7_rst", mk(0,0,0,0,0,0,0,0, 2'd0, 6'h00, 32'h0));
        rst_n = 1'b1;
        step("t7_reack", mk(1,1,0,0,0,0,0,0, 2'd0, 6'h00, 32'h0));
        exc_req_i = 1'b0;
        step("t7_jump", mk(0,0,0,0,1,0,1,0, 2'd3, 6'h33, 32'h600));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
